alu_wb_retire_buffer: RTL
=========================

Name: alu_wb_retire_buffer

Overview:
- Sits directly downstream of the ALU EX->WB flop stage.
- Captures each completing ALU instruction (wfid, pc, destination addresses, write enables) into a small in-order FIFO.
- Holds each entry until the shared SGPR/VGPR write-port arbiter grants it, then retires it: a one-cycle done pulse to issue/tracemon.
- The flop stage cannot stall, so the buffer never back-pressures it directly. It raises an almost-full signal so issue stops dispatching ALU instructions early enough.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two, 2..16.
- AFULL_THRESH, 2, out_almost_full asserts when count >= DEPTH - AFULL_THRESH (slack for in-flight EX instructions).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_wfid  in  6  wavefront id from the EX/WB stage.
- in_instr_pc  in  32  instruction PC.
- in_vgpr_dest_addr  in  10  VGPR destination.
- in_sgpr_dest_addr  in  9  SGPR destination.
- in_instr_done  in  1  valid: instruction completes this cycle.
- in_vgpr_dest_wr_en  in  1  VGPR write required.
- in_sgpr_dest_wr_en  in  1  SGPR write required.
- in_vcc_wr_en  in  1  VCC write required.
- rf_wr_grant  in  1  write-port arbiter grant for the current head.
- out_rf_wr_req  out  1  head valid and needs a register write.
- out_wfid  out  6  head wfid.
- out_instr_pc  out  32  head PC.
- out_vgpr_dest_addr  out  10  head VGPR address.
- out_sgpr_dest_addr  out  9  head SGPR address.
- out_vgpr_dest_wr_en  out  1  head VGPR write enable, qualified by the grant.
- out_sgpr_dest_wr_en  out  1  head SGPR write enable, qualified by the grant.
- out_vcc_wr_en  out  1  head VCC write enable, qualified by the grant.
- out_retire  out  1  one-cycle pulse: head popped this cycle.
- out_retire_wfid  out  6  wfid of the retiring entry (valid with out_retire).
- out_almost_full  out  1  throttle signal to issue.
- out_overflow  out  1  sticky error: a push was dropped.

Behaviour:
- Reset values: count, read/write pointers, out_overflow all 0. All outputs are 0 during and after reset until the first push.
- Entry fields: wfid, pc, vaddr, saddr, and the three wr_ens; 60 bits total.
- Push condition: in_instr_done == 1. When in_instr_done == 0, the write enables are ignored and nothing is stored.
- Head outputs are combinational from the registered FIFO head; there is no input bypass. An entry pushed in cycle N is first visible in cycle N+1.
- needs_port = head valid and (vgpr_wr_en | sgpr_wr_en | vcc_wr_en).
- out_rf_wr_req = needs_port.
- Pop condition is (needs_port & rf_wr_grant) | (head valid & !needs_port). A done-only entry retires without arbitration.
- out_*_wr_en = head wr_en & pop. Address and PC fields present the head value whenever the FIFO is non-empty, and 0 when empty.
- rf_wr_grant while empty, or while the head needs no port, is ignored.
- out_retire = pop. out_retire_wfid = head wfid when popping, else 0.
- Order is strictly FIFO; entries are never reordered.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: both take effect and count is unchanged. This applies when full as well, because the pop frees a slot in the same cycle.
- Push while full with no pop: the entry is dropped, out_overflow is set and stays set until rst, and count stays at DEPTH.
- out_almost_full is registered from the next count, so it is valid in the same cycle the count changes.
- Reset mid-operation flushes all entries without a retire pulse.

Decomposition:
- Shared package/defines (alu_definitions): field widths WFID_W=6, PC_W=32, VADDR_W=10, SADDR_W=9, and entry width/offset constants for packing.
- Sub-module alu_wb_fifo: a generic synchronous FIFO (DEPTH, WIDTH) with push, pop, count, full and empty. The top level adds the pack/unpack, needs_port logic, grant qualification, overflow flag and almost-full.

Test Plan:
- Reset, then push 1 entry (wfid=5, pc=0x100, vaddr=0x3, vgpr_en=1) with grant held 0 -> out_rf_wr_req=1 from the next cycle and holds. Grant=1 -> same cycle out_vgpr_dest_wr_en=1, out_retire=1, out_retire_wfid=5; next cycle out_rf_wr_req=0.
- Push a done-only entry (all wr_en=0, wfid=9), grant=0 -> retires 1 cycle after the push with out_retire=1, wfid=9, and all wr_en outputs 0.
- DEPTH=4, grant=0, push 4 entries wfid 1..4 -> out_almost_full=1 after the 2nd push. A 5th push -> out_overflow=1 and count stays 4. Grant=1 for 4 cycles -> retires in order 1,2,3,4.
- Full FIFO with push and grant in the same cycle -> count stays 4, no overflow, the new entry retires last.
- Wrap-around: 10 push/pop pairs with a one-cycle grant lag -> all 10 retire in order with PCs 0x0..0x24 step 4.
- Assert rst with 3 entries queued -> next cycle out_rf_wr_req=0, out_retire=0, out_overflow=0, out_almost_full=0.

Source files
------------

// File: rtl/alu_definitions.sv
// Field widths and bit positions for one buffered ALU completion record.
// The record is kept as a flat vector so the FIFO underneath stays generic.
package alu_definitions;

  localparam int WFID_W  = 6;
  localparam int PC_W    = 32;
  localparam int VADDR_W = 10;
  localparam int SADDR_W = 9;

  localparam int VCC_EN_OFF  = 0;
  localparam int SGPR_EN_OFF = 1;
  localparam int VGPR_EN_OFF = 2;
  localparam int SADDR_OFF   = 3;
  localparam int VADDR_OFF   = SADDR_OFF + SADDR_W;
  localparam int PC_OFF      = VADDR_OFF + VADDR_W;
  localparam int WFID_OFF    = PC_OFF + PC_W;
  localparam int ENTRY_W     = WFID_OFF + WFID_W;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [WFID_W-1:0]  wfid,
    input logic [PC_W-1:0]    pc,
    input logic [VADDR_W-1:0] vaddr,
    input logic [SADDR_W-1:0] saddr,
    input logic               vgpr_en,
    input logic               sgpr_en,
    input logic               vcc_en
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[WFID_OFF +: WFID_W]   = wfid;
    e[PC_OFF +: PC_W]       = pc;
    e[VADDR_OFF +: VADDR_W] = vaddr;
    e[SADDR_OFF +: SADDR_W] = saddr;
    e[VGPR_EN_OFF]          = vgpr_en;
    e[SGPR_EN_OFF]          = sgpr_en;
    e[VCC_EN_OFF]           = vcc_en;
    return e;
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only when a
// pop frees the slot in the same cycle, otherwise it is silently dropped.
module alu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 60
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_next_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o      = mem_q[rd_ptr_q];
  assign count_next_o = count_d;

endmodule

// File: rtl/alu_wb_retire_buffer.sv
// In-order holding buffer between the ALU EX/WB flops and the shared register
// write port; entries retire on grant, or immediately when no write is needed.
module alu_wb_retire_buffer
  import alu_definitions::*;
#(
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WFID_W-1:0]  in_wfid,
  input  logic [PC_W-1:0]    in_instr_pc,
  input  logic [VADDR_W-1:0] in_vgpr_dest_addr,
  input  logic [SADDR_W-1:0] in_sgpr_dest_addr,
  input  logic               in_instr_done,
  input  logic               in_vgpr_dest_wr_en,
  input  logic               in_sgpr_dest_wr_en,
  input  logic               in_vcc_wr_en,
  input  logic               rf_wr_grant,
  output logic               out_rf_wr_req,
  output logic [WFID_W-1:0]  out_wfid,
  output logic [PC_W-1:0]    out_instr_pc,
  output logic [VADDR_W-1:0] out_vgpr_dest_addr,
  output logic [SADDR_W-1:0] out_sgpr_dest_addr,
  output logic               out_vgpr_dest_wr_en,
  output logic               out_sgpr_dest_wr_en,
  output logic               out_vcc_wr_en,
  output logic               out_retire,
  output logic [WFID_W-1:0]  out_retire_wfid,
  output logic               out_almost_full,
  output logic               out_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_THRESH);

  logic [ENTRY_W-1:0] wr_entry, head_entry;
  logic [CW-1:0]      count_next;
  logic               fifo_full, fifo_empty;
  logic               head_valid, needs_port, pop;
  logic               head_ven, head_sen, head_cen;
  logic               almost_full_q, almost_full_d;
  logic               overflow_q, overflow_d;

  assign wr_entry = pack_entry(in_wfid, in_instr_pc, in_vgpr_dest_addr, in_sgpr_dest_addr,
                               in_vgpr_dest_wr_en, in_sgpr_dest_wr_en, in_vcc_wr_en);

  alu_wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (in_instr_done),
    .pop_i        (pop),
    .wdata_i      (wr_entry),
    .rdata_o      (head_entry),
    .count_next_o (count_next),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Masking with rst keeps a flush from emitting a retire pulse.
  assign head_valid = ~fifo_empty & ~rst;
  assign head_ven   = head_entry[VGPR_EN_OFF];
  assign head_sen   = head_entry[SGPR_EN_OFF];
  assign head_cen   = head_entry[VCC_EN_OFF];
  assign needs_port = head_valid & (head_ven | head_sen | head_cen);
  assign pop        = head_valid & (~needs_port | rf_wr_grant);

  assign out_rf_wr_req       = needs_port;
  assign out_wfid            = head_valid ? head_entry[WFID_OFF +: WFID_W]   : '0;
  assign out_instr_pc        = head_valid ? head_entry[PC_OFF +: PC_W]       : '0;
  assign out_vgpr_dest_addr  = head_valid ? head_entry[VADDR_OFF +: VADDR_W] : '0;
  assign out_sgpr_dest_addr  = head_valid ? head_entry[SADDR_OFF +: SADDR_W] : '0;
  assign out_vgpr_dest_wr_en = head_ven & pop;
  assign out_sgpr_dest_wr_en = head_sen & pop;
  assign out_vcc_wr_en       = head_cen & pop;
  assign out_retire          = pop;
  assign out_retire_wfid     = pop ? head_entry[WFID_OFF +: WFID_W] : '0;

  assign almost_full_d = (count_next >= AFULL_LVL);
  assign overflow_d    = overflow_q | (in_instr_done & fifo_full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign out_almost_full = almost_full_q;
  assign out_overflow    = overflow_q;

endmodule
